ecc_operand_loader: RTL and testbench

//  Input stage directly upstream of the ECC scalar-multiply core.
//  - Deserializes the nibble-serial operands a, prime, Px, Py and k into WIDTH-bit words.
//  - Presents the five words to the core with a valid/ready handshake.
//  - Holds the words stable until the core accepts them.

---
 rtl/ecc_operand_loader_if.sv | 33 +++
 rtl/ecc_operand_loader.sv | 137 +++++++++++++
 tb/tb_ecc_operand_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_operand_loader_if.sv
// Operand bus between the nibble-serial source, the operand loader and the ECC core.
// The slave modport is the loader; the master modport is the environment driving it.
interface ecc_operand_loader_if #(
    parameter int WIDTH = 32,
    parameter int NIB   = 4
);
    logic             i_start;
    logic [NIB-1:0]   i_a;
    logic [NIB-1:0]   i_prime;
    logic [NIB-1:0]   i_px;
    logic [NIB-1:0]   i_py;
    logic [NIB-1:0]   i_k;
    logic             i_ready;

    logic             o_valid;
    logic [WIDTH-1:0] o_a;
    logic [WIDTH-1:0] o_prime;
    logic [WIDTH-1:0] o_px;
    logic [WIDTH-1:0] o_py;
    logic [WIDTH-1:0] o_k;
    logic             o_busy;
    logic             o_err;

    modport master (
        output i_start, i_a, i_prime, i_px, i_py, i_k, i_ready,
        input  o_valid, o_a, o_prime, o_px, o_py, o_k, o_busy, o_err
    );

    modport slave (
        input  i_start, i_a, i_prime, i_px, i_py, i_k, i_ready,
        output o_valid, o_a, o_prime, o_px, o_py, o_k, o_busy, o_err
    );
endinterface

// File: rtl/ecc_operand_loader.sv
// Deserializes five nibble-serial ECC operands and presents them to the core with valid/ready.
// Optional range check on the assembled words is enabled by defining ECC_RANGE_CHECK_EN.
module ecc_operand_loader #(
    parameter int WIDTH = 32,
    parameter int NIB   = 4
) (
    input  logic               clk,
    input  logic               reset,
    ecc_operand_loader_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIB;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sh_a, sh_prime, sh_px, sh_py, sh_k;
    logic [WIDTH-1:0] nx_a, nx_prime, nx_px, nx_py, nx_k;

    // Next shift-register contents: the incoming nibble enters at the top, older nibbles move down.
    // NOTE: every signal written here is assigned on every evaluation, so no latch can be inferred.
    always_comb begin
        nx_a     = {bus.i_a,     sh_a[WIDTH-1:NIB]};
        nx_prime = {bus.i_prime, sh_prime[WIDTH-1:NIB]};
        nx_px    = {bus.i_px,    sh_px[WIDTH-1:NIB]};
        nx_py    = {bus.i_py,    sh_py[WIDTH-1:NIB]};
        nx_k     = {bus.i_k,     sh_k[WIDTH-1:NIB]};
    end

`ifdef ECC_RANGE_CHECK_EN
    logic range_bad;

    // Evaluated on the fully assembled words, i.e. including the nibble captured this cycle.
    always_comb begin
        range_bad = (nx_prime == '0)
                  | (nx_a  >= nx_prime)
                  | (nx_px >= nx_prime)
                  | (nx_py >= nx_prime);
    end
`else
    assign bus.o_err = 1'b0;
`endif

    // NOTE: all state and outputs are updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            sh_a        <= '0;
            sh_prime    <= '0;
            sh_px       <= '0;
            sh_py       <= '0;
            sh_k        <= '0;
            bus.o_a     <= '0;
            bus.o_prime <= '0;
            bus.o_px    <= '0;
            bus.o_py    <= '0;
            bus.o_k     <= '0;
            bus.o_valid <= 1'b0;
            bus.o_busy  <= 1'b0;
`ifdef ECC_RANGE_CHECK_EN
            bus.o_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state      <= S_LOAD;
                        count      <= '0;
                        sh_a       <= '0;
                        sh_prime   <= '0;
                        sh_px      <= '0;
                        sh_py      <= '0;
                        sh_k       <= '0;
                        bus.o_busy <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // A start pulse mid-frame discards the partial frame; its cycle carries no data.
                    if (bus.i_start) begin
                        count    <= '0;
                        sh_a     <= '0;
                        sh_prime <= '0;
                        sh_px    <= '0;
                        sh_py    <= '0;
                        sh_k     <= '0;
                    end else begin
                        sh_a     <= nx_a;
                        sh_prime <= nx_prime;
                        sh_px    <= nx_px;
                        sh_py    <= nx_py;
                        sh_k     <= nx_k;
                        count    <= count + 1'b1;
                        if (count == LAST) begin
                            state       <= S_HOLD;
                            bus.o_a     <= nx_a;
                            bus.o_prime <= nx_prime;
                            bus.o_px    <= nx_px;
                            bus.o_py    <= nx_py;
                            bus.o_k     <= nx_k;
                            bus.o_valid <= 1'b1;
`ifdef ECC_RANGE_CHECK_EN
                            bus.o_err   <= range_bad;
`endif
                        end
                    end
                end

                S_HOLD: begin
                    // Start pulses are ignored here; only the core's acceptance leaves HOLD.
                    if (bus.i_ready) begin
                        state       <= S_IDLE;
                        bus.o_valid <= 1'b0;
                        bus.o_busy  <= 1'b0;
`ifdef ECC_RANGE_CHECK_EN
                        bus.o_err   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    bus.o_valid <= 1'b0;
                    bus.o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_operand_loader.sv
// Randomized self-checking bench for ecc_operand_loader against a frame-level reference model.
module tb_ecc_operand_loader;
    localparam int WIDTH   = 32;
    localparam int NIB     = 4;
    localparam int NIBBLES = WIDTH / NIB;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct packed {
        word_t a;
        word_t prime;
        word_t px;
        word_t py;
        word_t k;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ecc_operand_loader_if #(.WIDTH(WIDTH), .NIB(NIB)) bus ();
    ecc_operand_loader #(.WIDTH(WIDTH), .NIB(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_cmp = 0;
    int     n_mis = 0;
    frame_t shown;      // operand set the outputs are expected to present

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NIB-1:0] nib_of(input word_t w, input int i);
        return NIB'(w >> (NIB * i));
    endfunction

    function automatic logic err_of(input frame_t f);
`ifdef ECC_RANGE_CHECK_EN
        return (f.prime == 0) || (f.a >= f.prime) || (f.px >= f.prime) || (f.py >= f.prime);
`else
        return 1'b0;
`endif
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.prime = word_t'($urandom);
        if ($urandom_range(0, 3) == 0) f.prime = word_t'($urandom_range(0, 3));
        f.a  = word_t'($urandom);
        f.px = word_t'($urandom);
        f.py = word_t'($urandom);
        f.k  = word_t'($urandom);
        if (f.prime != 0 && $urandom_range(0, 1) == 1) begin
            f.a  = f.a  % f.prime;
            f.px = f.px % f.prime;
            f.py = f.py % f.prime;
        end
        return f;
    endfunction

    task automatic drive_nib(input frame_t f, input int i);
        bus.i_a     = nib_of(f.a, i);
        bus.i_prime = nib_of(f.prime, i);
        bus.i_px    = nib_of(f.px, i);
        bus.i_py    = nib_of(f.py, i);
        bus.i_k     = nib_of(f.k, i);
    endtask

    task automatic drive_rand_nib();
        bus.i_a     = NIB'($urandom);
        bus.i_prime = NIB'($urandom);
        bus.i_px    = NIB'($urandom);
        bus.i_py    = NIB'($urandom);
        bus.i_k     = NIB'($urandom);
    endtask

    task automatic check_words(input string tag, input frame_t f);
        check({tag, ".o_a"},     bus.o_a,     f.a);
        check({tag, ".o_prime"}, bus.o_prime, f.prime);
        check({tag, ".o_px"},    bus.o_px,    f.px);
        check({tag, ".o_py"},    bus.o_py,    f.py);
        check({tag, ".o_k"},     bus.o_k,     f.k);
    endtask

    // Start pulse, optional partial frame of junk_n nibbles followed by a restart, then the full frame.
    task automatic load_frame(input string tag, input frame_t f, input frame_t junk,
                              input int junk_n, input logic ready_noise);
        bus.i_start = 1'b1;
        drive_rand_nib();
        tick();
        bus.i_start = 1'b0;
        check({tag, ".busy_start"}, word_t'(bus.o_busy), 1);
        check({tag, ".valid_start"}, word_t'(bus.o_valid), 0);
        if (junk_n > 0) begin
            for (int i = 0; i < junk_n; i++) begin
                drive_nib(junk, i);
                bus.i_ready = ready_noise ? 1'($urandom) : 1'b0;
                tick();
                check({tag, ".valid_junk"}, word_t'(bus.o_valid), 0);
            end
            bus.i_start = 1'b1;
            drive_rand_nib();
            tick();
            bus.i_start = 1'b0;
            check({tag, ".valid_restart"}, word_t'(bus.o_valid), 0);
        end
        for (int i = 0; i < NIBBLES; i++) begin
            drive_nib(f, i);
            bus.i_ready = ready_noise ? 1'($urandom) : 1'b0;
            tick();
            if (i < NIBBLES - 1) begin
                check({tag, ".valid_load"}, word_t'(bus.o_valid), 0);
                check({tag, ".busy_load"}, word_t'(bus.o_busy), 1);
            end
        end
        bus.i_ready = 1'b0;
        shown = f;
        check({tag, ".valid_rise"}, word_t'(bus.o_valid), 1);
        check({tag, ".err"}, word_t'(bus.o_err), word_t'(err_of(f)));
        check_words(tag, f);
    endtask

    task automatic hold_cycles(input string tag, input int n, input logic start_noise);
        for (int i = 0; i < n; i++) begin
            bus.i_ready = 1'b0;
            bus.i_start = start_noise ? 1'($urandom) : 1'b0;
            drive_rand_nib();
            tick();
            check({tag, ".valid_hold"}, word_t'(bus.o_valid), 1);
            check({tag, ".busy_hold"}, word_t'(bus.o_busy), 1);
            check({tag, ".err_hold"}, word_t'(bus.o_err), word_t'(err_of(shown)));
            check_words({tag, ".hold"}, shown);
        end
        bus.i_start = 1'b0;
    endtask

    task automatic release_hold(input string tag, input logic with_start);
        bus.i_ready = 1'b1;
        bus.i_start = with_start;
        drive_rand_nib();
        tick();
        bus.i_ready = 1'b0;
        bus.i_start = 1'b0;
        check({tag, ".valid_rel"}, word_t'(bus.o_valid), 0);
        check({tag, ".busy_rel"}, word_t'(bus.o_busy), 0);
        check({tag, ".err_rel"}, word_t'(bus.o_err), 0);
        check_words({tag, ".kept"}, shown);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_ready = 1'($urandom);
            drive_rand_nib();
            tick();
            check({tag, ".valid_idle"}, word_t'(bus.o_valid), 0);
            check({tag, ".busy_idle"}, word_t'(bus.o_busy), 0);
        end
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f, junk;

        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        drive_rand_nib();
        shown = '0;

        // Reset state, with start and ready asserted to show reset dominates.
        reset = 1'b1;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        repeat (3) tick();
        check("rst.valid", word_t'(bus.o_valid), 0);
        check("rst.busy", word_t'(bus.o_busy), 0);
        check("rst.err", word_t'(bus.o_err), 0);
        check_words("rst", shown);
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        reset = 1'b0;
        tick();

        // Directed frame, held for 20 cycles, then accepted.
        f = '{a: 32'h1, prime: 32'h17, px: 32'h3, py: 32'hA, k: 32'h5};
        load_frame("t1", f, f, 0, 1'b0);
        hold_cycles("t1", 20, 1'b0);
        release_hold("t2", 1'b0);
        idle_cycles("t2", 2);
        load_frame("t2b", rand_frame(), f, 0, 1'b0);
        hold_cycles("t2b", 2, 1'b0);
        release_hold("t2b", 1'b0);

        // Restart mid-frame: partial frame discarded.
        junk = '{a: '0, prime: '0, px: '0, py: '0, k: 32'h12345678};
        f = '{a: 32'h2, prime: 32'hFFFF_FFF1, px: 32'h4, py: 32'h6, k: 32'hCAFE_BABE};
        load_frame("t3", f, junk, 4, 1'b0);
        hold_cycles("t3", 1, 1'b0);
        release_hold("t3", 1'b0);

        // Reset at the fifth nibble of a load.
        f = rand_frame();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_nib(f, i);
            tick();
        end
        drive_nib(f, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        shown = '0;
        check("t4.valid", word_t'(bus.o_valid), 0);
        check("t4.busy", word_t'(bus.o_busy), 0);
        check("t4.err", word_t'(bus.o_err), 0);
        check_words("t4", shown);
        for (int i = 5; i < NIBBLES; i++) begin
            drive_nib(f, i);
            tick();
            check("t4.idle_valid", word_t'(bus.o_valid), 0);
            check("t4.idle_busy", word_t'(bus.o_busy), 0);
        end
        load_frame("t4b", rand_frame(), f, 0, 1'b0);
        hold_cycles("t4b", 1, 1'b0);

        // Start together with ready in HOLD: leaves HOLD, following nibbles ignored.
        release_hold("t5", 1'b1);
        f = rand_frame();
        for (int i = 0; i < NIBBLES + 1; i++) begin
            drive_nib(f, i % NIBBLES);
            tick();
            check("t5.valid", word_t'(bus.o_valid), 0);
            check("t5.busy", word_t'(bus.o_busy), 0);
        end

        // Range-check boundaries (expected 0 when the check is compiled out).
        f = '{a: 32'h1, prime: 32'h17, px: 32'h17, py: 32'hA, k: 32'h5};
        load_frame("t6a", f, f, 0, 1'b0);
        release_hold("t6a", 1'b0);
        f = '{a: 32'h1, prime: 32'h17, px: 32'h16, py: 32'hA, k: 32'h5};
        load_frame("t6b", f, f, 0, 1'b0);
        release_hold("t6b", 1'b0);
        f = '{a: 32'h0, prime: 32'h0, px: 32'h0, py: 32'h0, k: 32'h5};
        load_frame("t6c", f, f, 0, 1'b0);
        release_hold("t6c", 1'b0);

        // Randomized frames: restarts, ready noise during load, start noise during hold.
        for (int n = 0; n < 40; n++) begin
            f    = rand_frame();
            junk = rand_frame();
            load_frame("rnd", f, junk,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NIBBLES - 1)) : 0,
                       1'b1);
            hold_cycles("rnd", int'($urandom_range(0, 5)), 1'b1);
            release_hold("rnd", 1'($urandom));
            idle_cycles("rnd", int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
